pipeline_ctrl: RTL

Central pipeline sequencer for the five-stage ARM core. It combines three inputs into per-stage pipeline-register load, clear and bubble controls: the load-use stall request from the hazard unit, branch-taken from ID, and multi-cycle data-memory accesses in MEM. It runs a wait-state FSM for data memory and keeps saturating stall and flush performance counters.

---
 rtl/pipeline_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: central pipeline sequencer for the five-stage core.
//
// Combines the load-use stall request, the branch-taken flush and multi-cycle
// data-memory accesses into per-stage load / clear / bubble controls. A small
// wait-state FSM (RUN, MWAIT + 4-bit wait counter) freezes the pipe while a
// data-memory access completes. Saturating counters track stall cycles and
// branch squashes.
//
// Parameters
//   MEM_WAIT  extra wait cycles per data-memory access (0..15), 0 = single cycle
//   CNT_W     stall counter width
// Ports
//   CLK           clock, rising edge
//   RESET_N       asynchronous active-low reset
//   hz_stall      load-use stall request from the hazard unit
//   branch_taken  taken branch resolved in ID
//   mem_req       instruction in MEM performs a load or store
//   clr_cnt       synchronous clear of both performance counters
//   PC_ld, IF_ID_ld, ID_EX_ld, EX_MEM_ld, MEM_WB_ld   stage load enables
//   IF_ID_clr     squash IF/ID to NOP on this edge
//   ID_EX_bubble  select NOP control word into ID/EX
//   mem_busy      high while the FSM is in MWAIT
//   stall_cnt     cycles with PC_ld = 0, saturating
//   flush_cnt     branch squashes, saturating at 255
module pipeline_ctrl #(
  parameter int unsigned MEM_WAIT = 2,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             hz_stall,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             clr_cnt,
  output logic             PC_ld,
  output logic             IF_ID_ld,
  output logic             IF_ID_clr,
  output logic             ID_EX_bubble,
  output logic             ID_EX_ld,
  output logic             EX_MEM_ld,
  output logic             MEM_WB_ld,
  output logic             mem_busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [7:0]       flush_cnt
);

  localparam bit         HasWait  = (MEM_WAIT != 0);
  localparam logic [3:0] WaitInit = HasWait ? 4'(MEM_WAIT - 1) : 4'd0;

  typedef enum logic [0:0] {StRun, StMwait} state_e;

  state_e           state_q, state_d;
  logic [3:0]       wcnt_q, wcnt_d;
  logic [CNT_W-1:0] stall_q;
  logic [7:0]       flush_q;
  logic             run_rules;
  logic             flush_inc;

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;

  // Outputs are decoded from the registered state and the current inputs.
  // Holding RESET_N low forces the safe values: everything frozen, NOP in ID/EX.
  always_comb begin
    state_d      = state_q;
    wcnt_d       = wcnt_q;
    run_rules    = 1'b0;
    flush_inc    = 1'b0;
    PC_ld        = 1'b0;
    IF_ID_ld     = 1'b0;
    ID_EX_ld     = 1'b0;
    EX_MEM_ld    = 1'b0;
    MEM_WB_ld    = 1'b0;
    IF_ID_clr    = 1'b0;
    ID_EX_bubble = 1'b1;
    mem_busy     = 1'b0;

    if (RESET_N) begin
      ID_EX_bubble = 1'b0;
      mem_busy     = (state_q == StMwait);

      unique case (state_q)
        StRun: begin
          if (mem_req && HasWait) begin
            state_d = StMwait;
            wcnt_d  = WaitInit;
          end else begin
            run_rules = 1'b1;
          end
        end
        StMwait: begin
          if (wcnt_q != 4'd0) begin
            wcnt_d = wcnt_q - 4'd1;
          end else begin
            // Release cycle: MEM advances now, so mem_req here is stale.
            state_d   = StRun;
            run_rules = 1'b1;
          end
        end
      endcase

      if (run_rules) begin
        ID_EX_ld  = 1'b1;
        EX_MEM_ld = 1'b1;
        MEM_WB_ld = 1'b1;
        if (hz_stall) begin
          ID_EX_bubble = 1'b1;
        end else begin
          PC_ld    = 1'b1;
          IF_ID_ld = 1'b1;
          if (branch_taken) begin
            IF_ID_clr = 1'b1;
            flush_inc = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= StRun;
      wcnt_q  <= 4'd0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      if (clr_cnt) begin
        stall_q <= '0;
        flush_q <= '0;
      end else begin
        if (!PC_ld && (stall_q != {CNT_W{1'b1}})) begin
          stall_q <= stall_q + CNT_W'(1);
        end
        if (flush_inc && (flush_q != 8'hff)) begin
          flush_q <= flush_q + 8'd1;
        end
      end
    end
  end

endmodule
